// File: rtl/camera_fifo_pkg.sv
// Shared constants and width helpers for the uart word FIFO bridge.
package camera_fifo_pkg;

    localparam int BYTE_W = 8;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Word width for a given number of packed bytes.
    function automatic int word_w(input int bpw);
        return BYTE_W * bpw;
    endfunction

    // Pointer index width for a given FIFO depth.
    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction

    // Byte index width; at least one bit so BYTES_PER_WORD=1 still has a legal vector.
    function automatic int idx_w(input int bpw);
        return (bpw > 1) ? clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read port; occupancy derived from
// extra-bit read/write pointers.
module sync_fifo
    import camera_fifo_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [W-1:0]      wdata,
    input  logic              rd,
    output logic [W-1:0]      datout,
    output logic              dato,
    output logic              empy,
    output logic              full,
    output logic [ADDR_W:0]   level
);

    logic [ADDR_W:0] wp_q, wp_d;
    logic [ADDR_W:0] rp_q, rp_d;
    logic [W-1:0]    datout_q, datout_d;
    logic            dato_q, dato_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [ADDR_W:0] level_c;
    logic            full_c, empy_c;
    logic            wr_en, rd_en;

    // Pointer update, write/read enables and read-port next values.
    always_comb begin
        level_c  = wp_q - rp_q;
        full_c   = (level_c == (ADDR_W+1)'(DEPTH));
        empy_c   = (level_c == '0);
        wr_en    = push && !full_c && !flush;
        rd_en    = rd && !empy_c && !flush;
        wp_d     = wp_q;
        rp_d     = rp_q;
        datout_d = datout_q;
        dato_d   = 1'b0;
        if (flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (wr_en) begin
                wp_d = wp_q + (ADDR_W+1)'(1);
            end
            if (rd_en) begin
                rp_d     = rp_q + (ADDR_W+1)'(1);
                datout_d = mem_q[rp_q[ADDR_W-1:0]];
                dato_d   = 1'b1;
            end
        end
    end

    // Pointer and read-port registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q     <= '0;
            rp_q     <= '0;
            datout_q <= '0;
            dato_q   <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            datout_q <= datout_d;
            dato_q   <= dato_d;
        end
    end

    // Storage array; contents need no reset since occupancy is pointer-tracked.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q[ADDR_W-1:0]] <= wdata;
        end
    end

    assign datout = datout_q;
    assign dato   = dato_q;
    assign level  = level_c;
    assign full   = full_c;
    assign empy   = empy_c;

endmodule

// File: rtl/uart_word_fifo.sv
// Uart rx byte handshake, little-endian word packer and sticky overflow
// flag feeding a sync_fifo.
module uart_word_fifo
    import camera_fifo_pkg::*;
#(
    parameter int BYTES_PER_WORD = 1,
    parameter int DEPTH          = 16,
    localparam int W      = word_w(BYTES_PER_WORD),
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_avail,
    output logic              rx_ack,
    input  logic              flush,
    input  logic              rd,
    output logic [W-1:0]      datout,
    output logic              dato,
    output logic              empy,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int             K_W    = idx_w(BYTES_PER_WORD);
    localparam logic [K_W-1:0] LAST_K = K_W'(BYTES_PER_WORD - 1);

    logic           rx_ack_q, rx_ack_d;
    logic [K_W-1:0] k_q, k_d;
    logic [W-1:0]   word_q, word_d;
    logic           overflow_q, overflow_d;
    logic [W-1:0]   push_word;
    logic           accept;
    logic           push;
    logic           fifo_full;

    // Byte accept, lane insertion, word completion and overflow detection.
    always_comb begin
        accept     = rx_avail && !rx_ack_q;
        rx_ack_d   = accept;
        push_word  = word_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (k_q == K_W'(i)) begin
                push_word[i*BYTE_W +: BYTE_W] = rx_data;
            end
        end
        push       = 1'b0;
        k_d        = k_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        if (flush) begin
            // A byte accepted here is still acked but never stored.
            k_d        = '0;
            word_d     = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            if (k_q == LAST_K) begin
                push   = 1'b1;
                k_d    = '0;
                word_d = '0;
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end
            end else begin
                k_d    = k_q + K_W'(1);
                word_d = push_word;
            end
        end
    end

    // Handshake, packer and overflow registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_ack_q   <= 1'b0;
            k_q        <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_ack_q   <= rx_ack_d;
            k_q        <= k_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .push   (push),
        .wdata  (push_word),
        .rd     (rd),
        .datout (datout),
        .dato   (dato),
        .empy   (empy),
        .full   (fifo_full),
        .level  (level)
    );

    assign full     = fifo_full;
    assign rx_ack   = rx_ack_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_word_fifo.sv
// Bench for uart_word_fifo: cycle table on a 1-byte/4-deep instance,
// hand sequences on a 2-byte/4-deep instance.
module tb_uart_word_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: BYTES_PER_WORD=1, DEPTH=4
    logic       a_reset, a_av, a_fl, a_rd;
    logic [7:0] a_d;
    logic       a_ack, a_dato, a_empy, a_full, a_ovf;
    logic [7:0] a_dout;
    logic [2:0] a_lvl;

    // Instance B: BYTES_PER_WORD=2, DEPTH=4
    logic        b_reset, b_av, b_fl, b_rd;
    logic [7:0]  b_d;
    logic        b_ack, b_dato, b_empy, b_full, b_ovf;
    logic [15:0] b_dout;
    logic [2:0]  b_lvl;

    uart_word_fifo #(.BYTES_PER_WORD(1), .DEPTH(4)) dut_a (
        .clk(clk), .reset(a_reset), .rx_data(a_d), .rx_avail(a_av), .rx_ack(a_ack),
        .flush(a_fl), .rd(a_rd), .datout(a_dout), .dato(a_dato), .empy(a_empy),
        .full(a_full), .level(a_lvl), .overflow(a_ovf)
    );

    uart_word_fifo #(.BYTES_PER_WORD(2), .DEPTH(4)) dut_b (
        .clk(clk), .reset(b_reset), .rx_data(b_d), .rx_avail(b_av), .rx_ack(b_ack),
        .flush(b_fl), .rd(b_rd), .datout(b_dout), .dato(b_dato), .empy(b_empy),
        .full(b_full), .level(b_lvl), .overflow(b_ovf)
    );

    typedef struct {
        logic       rst;
        logic       av;
        logic [7:0] d;
        logic       fl;
        logic       rd;
        logic       ack;
        logic       dato;
        logic [7:0] dout;
        logic [2:0] lvl;
        logic       empy;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t v(input logic rst, input logic av, input logic [7:0] d,
                               input logic fl, input logic rd, input logic ack,
                               input logic dato, input logic [7:0] dout, input logic [2:0] lvl,
                               input logic empy, input logic full, input logic ovf);
        vec_t r;
        r.rst = rst; r.av = av; r.d = d; r.fl = fl; r.rd = rd;
        r.ack = ack; r.dato = dato; r.dout = dout; r.lvl = lvl;
        r.empy = empy; r.full = full; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic b_step(input logic av, input logic [7:0] d, input logic fl, input logic rd);
        b_av = av; b_d = d; b_fl = fl; b_rd = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b0; a_av = 1'b0; a_d = 8'h00; a_fl = 1'b0; a_rd = 1'b0;
        b_reset = 1'b0; b_av = 1'b0; b_d = 8'h00; b_fl = 1'b0; b_rd = 1'b0;

        //           rst av  d     fl rd   ack dato dout  lvl e  f  o
        tbl.push_back(v(0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 0, 0)); // reset
        tbl.push_back(v(1, 1, 8'h11, 0, 0,  1, 0, 8'h00, 1, 0, 0, 0)); // byte 0x11
        tbl.push_back(v(1, 1, 8'h11, 0, 0,  0, 0, 8'h00, 1, 0, 0, 0)); // avail held in ack cycle
        tbl.push_back(v(1, 1, 8'h22, 0, 0,  1, 0, 8'h00, 2, 0, 0, 0)); // byte 0x22
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 2, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'h11, 1, 0, 0, 0)); // rd
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'h22, 0, 1, 0, 0)); // rd
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h22, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 0, 8'h22, 0, 1, 0, 0)); // rd on empty
        tbl.push_back(v(1, 1, 8'hA1, 0, 0,  1, 0, 8'h22, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h22, 1, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hA2, 0, 0,  1, 0, 8'h22, 2, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h22, 2, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hA3, 0, 0,  1, 0, 8'h22, 3, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h22, 3, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hA4, 0, 0,  1, 0, 8'h22, 4, 0, 1, 0)); // now full
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h22, 4, 0, 1, 0));
        tbl.push_back(v(1, 1, 8'hA5, 0, 0,  1, 0, 8'h22, 4, 0, 1, 1)); // dropped
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h22, 4, 0, 1, 1));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'hA1, 3, 0, 0, 1));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'hA2, 2, 0, 0, 1));
        tbl.push_back(v(1, 1, 8'hA6, 0, 1,  1, 1, 8'hA3, 2, 0, 0, 1)); // push+pop at level 2
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hA3, 2, 0, 0, 1));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'hA4, 1, 0, 0, 1));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'hA6, 0, 1, 0, 1));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 0, 8'hA6, 0, 1, 0, 1));
        tbl.push_back(v(1, 0, 8'h00, 1, 0,  0, 0, 8'hA6, 0, 1, 0, 0)); // flush clears overflow
        tbl.push_back(v(1, 1, 8'hB1, 0, 0,  1, 0, 8'hA6, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hA6, 1, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hB2, 0, 0,  1, 0, 8'hA6, 2, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hA6, 2, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hB3, 0, 0,  1, 0, 8'hA6, 3, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hA6, 3, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hB4, 0, 0,  1, 0, 8'hA6, 4, 0, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hA6, 4, 0, 1, 0));
        tbl.push_back(v(1, 1, 8'hB5, 0, 1,  1, 1, 8'hB1, 3, 0, 0, 1)); // push at full + rd: dropped
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 1, 8'hB2, 2, 0, 0, 1));
        tbl.push_back(v(1, 1, 8'hC1, 1, 0,  1, 0, 8'hB2, 0, 1, 0, 0)); // byte in flush cycle
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hB2, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 1,  0, 0, 8'hB2, 0, 1, 0, 0)); // C1 was discarded
        tbl.push_back(v(1, 1, 8'hD1, 0, 0,  1, 0, 8'hB2, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hB2, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 1, 1,  0, 0, 8'hB2, 0, 1, 0, 0)); // flush beats rd
        tbl.push_back(v(1, 1, 8'hE1, 0, 0,  1, 0, 8'hB2, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hB2, 1, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hE2, 0, 0,  1, 0, 8'hB2, 2, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'hB2, 2, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'hE3, 0, 0,  1, 0, 8'hB2, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'hE4, 0, 1,  0, 0, 8'h00, 0, 1, 0, 0)); // mid-stream reset
        tbl.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            a_reset = tbl[i].rst; a_av = tbl[i].av; a_d = tbl[i].d;
            a_fl = tbl[i].fl; a_rd = tbl[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("a%0d.rx_ack", i),   32'(a_ack),  32'(tbl[i].ack));
            chk($sformatf("a%0d.dato", i),     32'(a_dato), 32'(tbl[i].dato));
            chk($sformatf("a%0d.datout", i),   32'(a_dout), 32'(tbl[i].dout));
            chk($sformatf("a%0d.level", i),    32'(a_lvl),  32'(tbl[i].lvl));
            chk($sformatf("a%0d.empy", i),     32'(a_empy), 32'(tbl[i].empy));
            chk($sformatf("a%0d.full", i),     32'(a_full), 32'(tbl[i].full));
            chk($sformatf("a%0d.overflow", i), 32'(a_ovf),  32'(tbl[i].ovf));
        end

        // Two-byte packing on instance B.
        b_step(0, 8'h00, 0, 0);
        chk("b.reset_level", 32'(b_lvl), 32'd0);
        chk("b.reset_empy", 32'(b_empy), 32'd1);
        b_reset = 1'b1;
        b_step(1, 8'h34, 0, 0);
        chk("b.lo_ack", 32'(b_ack), 32'd1);
        chk("b.lo_level", 32'(b_lvl), 32'd0);
        b_step(0, 8'h00, 0, 0);
        b_step(1, 8'h12, 0, 0);
        chk("b.hi_ack", 32'(b_ack), 32'd1);
        chk("b.hi_level", 32'(b_lvl), 32'd1);
        b_step(0, 8'h00, 0, 0);
        b_step(0, 8'h00, 0, 1);
        chk("b.word1_dato", 32'(b_dato), 32'd1);
        chk("b.word1_datout", 32'(b_dout), 32'h1234);
        chk("b.word1_level", 32'(b_lvl), 32'd0);
        b_step(1, 8'hAA, 0, 0);
        chk("b.partial_ack", 32'(b_ack), 32'd1);
        chk("b.partial_level", 32'(b_lvl), 32'd0);
        b_step(0, 8'h00, 0, 0);
        chk("b.partial_dato", 32'(b_dato), 32'd0);
        b_step(0, 8'h00, 1, 0);
        chk("b.flush_level", 32'(b_lvl), 32'd0);
        chk("b.flush_ovf", 32'(b_ovf), 32'd0);
        chk("b.flush_empy", 32'(b_empy), 32'd1);
        b_step(1, 8'h78, 0, 0);
        chk("b.clean_lo_level", 32'(b_lvl), 32'd0);
        b_step(0, 8'h00, 0, 0);
        b_step(1, 8'h56, 0, 0);
        chk("b.clean_hi_level", 32'(b_lvl), 32'd1);
        b_step(0, 8'h00, 0, 0);
        b_step(0, 8'h00, 0, 1);
        chk("b.word2_dato", 32'(b_dato), 32'd1);
        chk("b.word2_datout", 32'(b_dout), 32'h5678);
        chk("b.word2_empy", 32'(b_empy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
